// File: rtl/sc_shift_arbiter.sv
// Shares one shift-register datapath between two player FSMs.
// Clears win over shifts, ties go round-robin, and each issued command is followed by a settle window.
module sc_shift_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       SC_SHIFTARBITER_CLOCK_50,
    input  logic       SC_SHIFTARBITER_RESET_InHigh,
    input  logic       SC_SHIFTARBITER_REQ0_clear_InLow,
    input  logic [1:0] SC_SHIFTARBITER_REQ0_shiftselection_In,
    input  logic       SC_SHIFTARBITER_REQ1_clear_InLow,
    input  logic [1:0] SC_SHIFTARBITER_REQ1_shiftselection_In,
    output logic       SC_SHIFTARBITER_clear_OutLow,
    output logic [1:0] SC_SHIFTARBITER_shiftselection_Out,
    output logic [1:0] SC_SHIFTARBITER_grant_Out,
    output logic [1:0] SC_SHIFTARBITER_overflow_Out,
    output logic       SC_SHIFTARBITER_busy_Out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CMD_CLEAR = 2'b00,
        CMD_LEFT  = 2'b01,
        CMD_RIGHT = 2'b10
    } cmd_t;

    localparam logic [3:0] SETTLE_LOAD =
        (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

    logic       clk;
    logic       rst;
    logic [1:0] reqClearN;
    logic [1:0] reqCode [2];
    logic [1:0] reqValid;
    cmd_t       reqCmd [2];

    state_t     state_q, state_d;
    logic [1:0] slotValid_q, slotValid_d;
    cmd_t       slotCmd_q [2];
    cmd_t       slotCmd_d [2];
    cmd_t       issueCmd_q, issueCmd_d;
    logic       issueOwner_q, issueOwner_d;
    logic       ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] overflow_q, overflow_d;

    logic [1:0] isClear;
    logic       anyValid;
    logic       sel;
    logic       consume;

    assign clk        = SC_SHIFTARBITER_CLOCK_50;
    assign rst        = SC_SHIFTARBITER_RESET_InHigh;
    assign reqClearN  = {SC_SHIFTARBITER_REQ1_clear_InLow, SC_SHIFTARBITER_REQ0_clear_InLow};
    assign reqCode[0] = SC_SHIFTARBITER_REQ0_shiftselection_In;
    assign reqCode[1] = SC_SHIFTARBITER_REQ1_shiftselection_In;

    // A clear in the same cycle as a shift masks the shift entirely.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            reqValid[i] = 1'b0;
            reqCmd[i]   = CMD_CLEAR;
            if (!reqClearN[i]) begin
                reqValid[i] = 1'b1;
                reqCmd[i]   = CMD_CLEAR;
            end else if (reqCode[i] == 2'b01) begin
                reqValid[i] = 1'b1;
                reqCmd[i]   = CMD_LEFT;
            end else if (reqCode[i] == 2'b10) begin
                reqValid[i] = 1'b1;
                reqCmd[i]   = CMD_RIGHT;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            isClear[i] = slotValid_q[i] && (slotCmd_q[i] == CMD_CLEAR);
        end
        anyValid = |slotValid_q;
        if (&slotValid_q) begin
            sel = (isClear[0] != isClear[1]) ? isClear[1] : ~ptr_q;
        end else begin
            sel = slotValid_q[1];
        end
        consume = (state_q == IDLE) && anyValid;
    end

    always_comb begin
        state_d      = state_q;
        issueCmd_d   = issueCmd_q;
        issueOwner_d = issueOwner_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (anyValid) begin
                    issueCmd_d   = slotCmd_q[sel];
                    issueOwner_d = sel;
                    ptr_d        = sel;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (SETTLE_CYCLES == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d = SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A slot emptied by selection at the same edge takes the new request without flagging overflow.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            slotValid_d[i] = slotValid_q[i];
            slotCmd_d[i]   = slotCmd_q[i];
            overflow_d[i]  = 1'b0;
            if (reqValid[i]) begin
                slotValid_d[i] = 1'b1;
                slotCmd_d[i]   = reqCmd[i];
                overflow_d[i]  = slotValid_q[i] && !(consume && (sel == 1'(i)));
            end else if (consume && (sel == 1'(i))) begin
                slotValid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            slotValid_q  <= 2'b00;
            slotCmd_q[0] <= CMD_CLEAR;
            slotCmd_q[1] <= CMD_CLEAR;
            issueCmd_q   <= CMD_CLEAR;
            issueOwner_q <= 1'b0;
            ptr_q        <= 1'b1;
            cnt_q        <= 4'd0;
            overflow_q   <= 2'b00;
        end else begin
            state_q      <= state_d;
            slotValid_q  <= slotValid_d;
            slotCmd_q[0] <= slotCmd_d[0];
            slotCmd_q[1] <= slotCmd_d[1];
            issueCmd_q   <= issueCmd_d;
            issueOwner_q <= issueOwner_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            overflow_q   <= overflow_d;
        end
    end

    always_comb begin
        SC_SHIFTARBITER_clear_OutLow       = 1'b1;
        SC_SHIFTARBITER_shiftselection_Out = 2'b11;
        SC_SHIFTARBITER_grant_Out          = 2'b00;
        if (state_q == ISSUE) begin
            SC_SHIFTARBITER_grant_Out = issueOwner_q ? 2'b10 : 2'b01;
            unique case (issueCmd_q)
                CMD_CLEAR: SC_SHIFTARBITER_clear_OutLow       = 1'b0;
                CMD_LEFT:  SC_SHIFTARBITER_shiftselection_Out = 2'b01;
                CMD_RIGHT: SC_SHIFTARBITER_shiftselection_Out = 2'b10;
                default:   SC_SHIFTARBITER_shiftselection_Out = 2'b11;
            endcase
        end
    end

    assign SC_SHIFTARBITER_overflow_Out = overflow_q;
    assign SC_SHIFTARBITER_busy_Out     = (state_q != IDLE) || anyValid;

endmodule

// File: tb/tb_sc_shift_arbiter.sv
// Directed bench for sc_shift_arbiter: expected issues are queued when requests are driven
// and popped whenever a grant appears on the outputs.
module tb_sc_shift_arbiter;

    typedef struct {
        int         cyc;
        logic       clr;
        logic [1:0] shift;
        logic [1:0] grant;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       r0Clr = 1'b1;
    logic [1:0] r0Code = 2'b00;
    logic       r1Clr = 1'b1;
    logic [1:0] r1Code = 2'b00;
    logic       outClr;
    logic [1:0] outShift;
    logic [1:0] outGrant;
    logic [1:0] outOvf;
    logic       outBusy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ovfCycle = -1;
    logic [1:0] ovfMask = 2'b00;
    exp_t sb[$];

    sc_shift_arbiter #(.SETTLE_CYCLES(2)) dut (
        .SC_SHIFTARBITER_CLOCK_50              (clk),
        .SC_SHIFTARBITER_RESET_InHigh          (rst),
        .SC_SHIFTARBITER_REQ0_clear_InLow      (r0Clr),
        .SC_SHIFTARBITER_REQ0_shiftselection_In(r0Code),
        .SC_SHIFTARBITER_REQ1_clear_InLow      (r1Clr),
        .SC_SHIFTARBITER_REQ1_shiftselection_In(r1Code),
        .SC_SHIFTARBITER_clear_OutLow          (outClr),
        .SC_SHIFTARBITER_shiftselection_Out    (outShift),
        .SC_SHIFTARBITER_grant_Out             (outGrant),
        .SC_SHIFTARBITER_overflow_Out          (outOvf),
        .SC_SHIFTARBITER_busy_Out              (outBusy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic c0, input logic [1:0] s0, input logic c1, input logic [1:0] s1);
        r0Clr  = c0;
        r0Code = s0;
        r1Clr  = c1;
        r1Code = s1;
    endtask

    // Outputs are sampled on the falling edge, mid-cycle.
    task automatic observe();
        exp_t e;
        checkOutput("overflow", 8'(outOvf), (cyc == ovfCycle) ? 8'(ovfMask) : 8'h00);
        if (outGrant !== 2'b00) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_grant", 8'(outGrant), 8'h00);
            end else begin
                e = sb.pop_front();
                checkOutput("issue_cycle", 8'(cyc), 8'(e.cyc));
                checkOutput("issue_clear", 8'(outClr), 8'(e.clr));
                checkOutput("issue_shift", 8'(outShift), 8'(e.shift));
                checkOutput("issue_grant", 8'(outGrant), 8'(e.grant));
            end
        end else begin
            checkOutput("idle_clear", 8'(outClr), 8'h01);
            checkOutput("idle_shift", 8'(outShift), 8'h03);
            if (sb.size() != 0 && cyc > sb[0].cyc) begin
                checkOutput("missed_issue", 8'(outGrant), 8'(sb[0].grant));
                void'(sb.pop_front());
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        observe();
    endtask

    task automatic runIdle(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b1, 2'b00, 1'b1, 2'b00);
            step();
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 2'b00, 1'b1, 2'b00);
        rst = 1'b1;
        #1;
        checkOutput("rst_clear", 8'(outClr), 8'h01);
        checkOutput("rst_shift", 8'(outShift), 8'h03);
        checkOutput("rst_grant", 8'(outGrant), 8'h00);
        checkOutput("rst_overflow", 8'(outOvf), 8'h00);
        checkOutput("rst_busy", 8'(outBusy), 8'h00);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        ovfCycle = -1;
        ovfMask  = 2'b00;
        cyc = 0;
    endtask

    initial begin
        @(negedge clk);

        // Idle after reset
        doReset();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 2'b00, 1'b1, 2'b00);
            step();
            checkOutput("idle_busy", 8'(outBusy), 8'h00);
        end
        checkOutput("t1_drained", 8'(sb.size()), 8'h00);

        // Single left shift with busy profile
        doReset();
        sb.push_back('{2, 1'b1, 2'b01, 2'b01});
        applyStimulus(1'b1, 2'b01, 1'b1, 2'b00);
        step();
        checkOutput("t2_busy", 8'(outBusy), 8'h01);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 2'b00, 1'b1, 2'b00);
            step();
            checkOutput("t2_busy", 8'(outBusy), (cyc <= 4) ? 8'h01 : 8'h00);
        end
        checkOutput("t2_drained", 8'(sb.size()), 8'h00);

        // Two shifts at once: requester 0 wins the first tie
        doReset();
        sb.push_back('{2, 1'b1, 2'b10, 2'b01});
        sb.push_back('{6, 1'b1, 2'b01, 2'b10});
        applyStimulus(1'b1, 2'b10, 1'b1, 2'b01);
        step();
        runIdle(8);
        checkOutput("t3_drained", 8'(sb.size()), 8'h00);

        // Clear beats shift regardless of pointer
        doReset();
        sb.push_back('{2, 1'b0, 2'b11, 2'b10});
        sb.push_back('{6, 1'b1, 2'b01, 2'b01});
        applyStimulus(1'b1, 2'b01, 1'b0, 2'b00);
        step();
        runIdle(8);
        checkOutput("t4_drained", 8'(sb.size()), 8'h00);

        // Pending slot overwritten before it is consumed
        doReset();
        ovfCycle = 5;
        ovfMask  = 2'b01;
        sb.push_back('{2, 1'b1, 2'b01, 2'b10});
        sb.push_back('{6, 1'b1, 2'b10, 2'b01});
        applyStimulus(1'b1, 2'b00, 1'b1, 2'b01);
        step();
        runIdle(2);
        applyStimulus(1'b1, 2'b01, 1'b1, 2'b00);
        step();
        applyStimulus(1'b1, 2'b10, 1'b1, 2'b00);
        step();
        runIdle(8);
        checkOutput("t5_drained", 8'(sb.size()), 8'h00);

        // Reset during the settle window discards the pending request
        doReset();
        sb.push_back('{2, 1'b1, 2'b01, 2'b01});
        applyStimulus(1'b1, 2'b01, 1'b1, 2'b00);
        step();
        applyStimulus(1'b1, 2'b00, 1'b1, 2'b10);
        step();
        applyStimulus(1'b1, 2'b00, 1'b1, 2'b00);
        step();
        checkOutput("t6_busy_settle", 8'(outBusy), 8'h01);
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_clear", 8'(outClr), 8'h01);
        checkOutput("t6_rst_shift", 8'(outShift), 8'h03);
        checkOutput("t6_rst_grant", 8'(outGrant), 8'h00);
        checkOutput("t6_rst_busy", 8'(outBusy), 8'h00);
        #1;
        rst = 1'b0;
        runIdle(8);
        checkOutput("t6_busy_after", 8'(outBusy), 8'h00);
        checkOutput("t6_drained", 8'(sb.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_shift_arbiter.md
Name: sc_shift_arbiter

Overview:
- Arbiter that shares one shift-register datapath between two player state machines (JUG1/JUG2).
- Each requester issues single-cycle shift-left, shift-right or clear commands in the codebase's encoding.
- Buffers one pending command per requester, grants one command at a time (clear first, then round-robin), and holds off for a settle window after each issued command so the edge comparators can update.
- Sits between the player FSMs and the shared shift register.

Parameters:
- SETTLE_CYCLES, 2, idle cycles after each issued command before the next selection. Legal range 0..15, 4-bit counter.

Ports:
- SC_SHIFTARBITER_CLOCK_50  in  1  system clock
- SC_SHIFTARBITER_RESET_InHigh  in  1  reset, asynchronous, active-high
- SC_SHIFTARBITER_REQ0_clear_InLow  in  1  requester 0 clear request, active-low
- SC_SHIFTARBITER_REQ0_shiftselection_In  in  2  requester 0 shift code: 01 left, 10 right, 11/00 none
- SC_SHIFTARBITER_REQ1_clear_InLow  in  1  requester 1 clear request, active-low
- SC_SHIFTARBITER_REQ1_shiftselection_In  in  2  requester 1 shift code, same encoding
- SC_SHIFTARBITER_clear_OutLow  out  1  clear to shared shift register, active-low
- SC_SHIFTARBITER_shiftselection_Out  out  2  shift code to shared register (01/10/11)
- SC_SHIFTARBITER_grant_Out  out  2  one-hot owner of the command on the outputs this cycle; 00 when none
- SC_SHIFTARBITER_overflow_Out  out  2  per-requester one-cycle pulse: pending command overwritten
- SC_SHIFTARBITER_busy_Out  out  1  1 when state != IDLE or any pending slot is valid

Behaviour:
- Reset (async, immediate): state IDLE; both slots invalid; settle counter 0; round-robin pointer = 1, so requester 0 wins the first tie.
- Reset output values: clear_OutLow=1, shiftselection=11, grant=00, overflow=00, busy=0.
- Request detection, per requester per cycle: clear_InLow==0 gives CLEAR; else code 01 gives LEFT; else code 10 gives RIGHT; else no request.
- Clear and shift in the same cycle from the same requester capture CLEAR only.
- Pending slots: each holds a valid bit plus a 2-bit command, loaded at the clock edge ending the request cycle.
- Slot already valid and not consumed at that edge: the new command overwrites it, and overflow[i] goes 1 for the following cycle.
- Slot consumed at the same edge a new request arrives: the new command loads with no overflow.
- FSM states: IDLE, ISSUE, SETTLE.
- IDLE:
  - No valid slot: stay in IDLE.
  - Otherwise select a slot: any CLEAR beats any shift.
  - Within the same class, pick the requester != pointer.
  - At the edge: copy the selected command into the issue register, invalidate that slot, set pointer = selected requester, go to ISSUE.
- ISSUE: exactly one cycle.
  - Outputs decode the issue register: CLEAR gives clear_OutLow=0, shift=11; LEFT gives 01; RIGHT gives 10.
  - grant = one-hot of the issuing requester.
  - Next state is SETTLE with counter loaded to SETTLE_CYCLES-1, or IDLE if SETTLE_CYCLES==0.
- SETTLE: outputs at idle values; counter decrements each cycle; when counter==0, go to IDLE.
- Outputs in IDLE and SETTLE: clear_OutLow=1, shiftselection=11, grant=00.
- Latency: a request in cycle c appears on the outputs in cycle c+2 if the arbiter is idle and wins.
- Issue spacing: minimum SETTLE_CYCLES+2 cycles between consecutive issues.
- Requests keep being captured in every state. Slots are never cleared except by issue or reset.
- Async reset mid-ISSUE/SETTLE: pending commands are discarded and never issued.

Test Plan:
- Reset asserted then released, no requests -> outputs stay clear=1, shift=11, grant=00, overflow=00, busy=0.
- REQ0 code 01 in cycle 0 only, SETTLE_CYCLES=2 -> cycle 2: shift=01, grant=01 for one cycle; busy=1 cycles 1..4; busy=0 from cycle 5.
- REQ0 code 10 and REQ1 code 01 both in cycle 0 -> cycle 2: shift=10, grant=01; cycle 6: shift=01, grant=10; no overflow.
- REQ0 code 01 and REQ1 clear_InLow=0 in cycle 0 -> cycle 2: clear_OutLow=0, shift=11, grant=10; cycle 6: shift=01, grant=01.
- REQ1 01 in cycle 0; REQ0 01 in cycle 3; REQ0 10 in cycle 4 (slot not yet consumed) -> overflow=01 in cycle 5 only; REQ0 issues shift=10 once; LEFT never issued.
- REQ0 01 in cycle 0, REQ1 10 in cycle 1, reset pulsed in cycle 3 (SETTLE) -> outputs at reset values immediately; no grant ever for REQ1; busy=0.
